bin2bcd_emitter: RTL and testbench

Sequential binary-to-BCD converter for the calculator datapath: takes a 14-bit binary result, converts it with a shift-and-add-3 (double-dabble) engine, and registers the 4-digit packed BCD value. It then replays the value as a digit stream (digit, digit index, new-digit strobe) on the same interface the operand-entry logic consumes. This lets results be written back as operands or sent to the display path.

---
 rtl/bin2bcd_emitter_if.sv | 24 ++
 rtl/bin2bcd_emitter.sv | 154 +++++++++++++++
 tb/tb_bin2bcd_emitter.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/bin2bcd_emitter_if.sv
// Handshake and result bus between the binary-to-BCD emitter and its host.
// The master drives the request side; the slave (converter) drives the results.
interface bin2bcd_emitter_if;
    logic        start;
    logic [13:0] binary;
    logic        hold;
    logic        busy;
    logic        bcdValid;
    logic [15:0] opBCD;
    logic        ovf;
    logic [3:0]  digits;
    logic [1:0]  digitNumber;
    logic        newNumber;

    modport master (
        output start, binary, hold,
        input  busy, bcdValid, opBCD, ovf, digits, digitNumber, newNumber
    );

    modport slave (
        input  start, binary, hold,
        output busy, bcdValid, opBCD, ovf, digits, digitNumber, newNumber
    );
endinterface

// File: rtl/bin2bcd_emitter.sv
// 14-bit binary to 4-digit BCD converter (double-dabble) with MS-first digit replay.
// Optional build macro OVF_SATURATE_EN: results above 9999 load and stream 16'h9999.
module bin2bcd_emitter (
    input  logic               clk,
    input  logic               rst,
    bin2bcd_emitter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [13:0] shift_r;
    logic [19:0] scratch_r;
    logic [3:0]  cnt_r;
    logic        busy_r;
    logic        bcd_valid_r;
    logic [15:0] op_bcd_r;
    logic        ovf_r;
    logic [3:0]  digits_r;
    logic [1:0]  digit_num_r;
    logic        new_number_r;
    logic [33:0] step_s;
    logic [15:0] load_s;

    // One double-dabble iteration: per-nibble add-3 (no inter-nibble carry), then shift left.
    function automatic logic [33:0] dabble_step(input logic [19:0] s, input logic [13:0] b);
        logic [19:0] adj;
        for (int i = 0; i < 5; i++) begin
            adj[i*4 +: 4] = (s[i*4 +: 4] >= 4'd5) ? (s[i*4 +: 4] + 4'd3) : s[i*4 +: 4];
        end
        return {adj, b} << 1;
    endfunction

    function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] idx);
        logic [3:0] n;
        case (idx)
            2'd3:    n = v[15:12];
            2'd2:    n = v[11:8];
            2'd1:    n = v[7:4];
            2'd0:    n = v[3:0];
            default: n = 4'd0;
        endcase
        return n;
    endfunction

    // Next-state selection and the datapath value loaded into opBCD on the last iteration.
    always_comb begin
        state_nxt_s = state_r;
        step_s      = dabble_step(scratch_r, shift_r);
`ifdef OVF_SATURATE_EN
        load_s      = ovf_r ? 16'h9999 : step_s[29:14];
`else
        load_s      = step_s[29:14];
`endif
        case (state_r)
            IDLE: begin
                if (bus.start) state_nxt_s = CONV;
                else           state_nxt_s = IDLE;
            end
            CONV: begin
                if (cnt_r == 4'd13) state_nxt_s = EMIT;
                else                state_nxt_s = CONV;
            end
            EMIT: begin
                if (!bus.hold && (digit_num_r == 2'd0)) state_nxt_s = IDLE;
                else                                    state_nxt_s = EMIT;
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= IDLE;
        else      state_r <= state_nxt_s;
    end

    // Conversion datapath and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_r      <= 14'd0;
            scratch_r    <= 20'd0;
            cnt_r        <= 4'd0;
            busy_r       <= 1'b0;
            bcd_valid_r  <= 1'b0;
            op_bcd_r     <= 16'h0000;
            ovf_r        <= 1'b0;
            digits_r     <= 4'd0;
            digit_num_r  <= 2'd0;
            new_number_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    bcd_valid_r  <= 1'b0;
                    new_number_r <= 1'b0;
                    if (bus.start) begin
                        shift_r   <= bus.binary;
                        scratch_r <= 20'd0;
                        ovf_r     <= (bus.binary > 14'd9999);
                        cnt_r     <= 4'd0;
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                CONV: begin
                    {scratch_r, shift_r} <= step_s;
                    cnt_r                <= cnt_r + 4'd1;
                    if (cnt_r == 4'd13) begin
                        op_bcd_r     <= load_s;
                        bcd_valid_r  <= 1'b1;
                        digit_num_r  <= 2'd3;
                        digits_r     <= load_s[15:12];
                        new_number_r <= 1'b1;
                    end else begin
                        bcd_valid_r  <= 1'b0;
                    end
                end
                EMIT: begin
                    bcd_valid_r <= 1'b0;
                    if (bus.hold) begin
                        new_number_r <= 1'b0;
                    end else if (digit_num_r == 2'd0) begin
                        new_number_r <= 1'b0;
                        busy_r       <= 1'b0;
                    end else begin
                        digit_num_r  <= digit_num_r - 2'd1;
                        digits_r     <= nibble_sel(op_bcd_r, digit_num_r - 2'd1);
                        new_number_r <= 1'b1;
                    end
                end
                default: begin
                    bcd_valid_r  <= 1'b0;
                    new_number_r <= 1'b0;
                    busy_r       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.bcdValid    = bcd_valid_r;
    assign bus.opBCD       = op_bcd_r;
    assign bus.ovf         = ovf_r;
    assign bus.digits      = digits_r;
    assign bus.digitNumber = digit_num_r;
    assign bus.newNumber   = new_number_r;

endmodule

// File: tb/tb_bin2bcd_emitter.sv
// Directed self-checking bench for bin2bcd_emitter: conversion values, digit stream,
// hold stalls, overflow, ignored starts and asynchronous reset.
module tb_bin2bcd_emitter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    bin2bcd_emitter_if bus ();

    bin2bcd_emitter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Accept a start at E0 and return just after E0.
    task automatic start_conv(input logic [13:0] v);
        bus.binary = v;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic test_reset_state;
        rst = 1'b0;
        bus.start = 1'b0; bus.binary = 14'd0; bus.hold = 1'b0;
        tick(); tick();
        checks++;
        if ({bus.busy, bus.bcdValid, bus.opBCD, bus.ovf, bus.digits, bus.digitNumber, bus.newNumber} !== 26'd0) begin
            errors++;
            $display("FAIL reset_state got busy=%b v=%b bcd=%h ovf=%b d=%h n=%0d nn=%b want all zero",
                     bus.busy, bus.bcdValid, bus.opBCD, bus.ovf, bus.digits, bus.digitNumber, bus.newNumber);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_basic_1234;
        logic [15:0] exp;
        exp = 16'h1234;
        start_conv(14'd1234);
        checks++;
        if ({bus.busy, bus.ovf, bus.bcdValid} !== 3'b100) begin
            errors++;
            $display("FAIL e0_busy got busy=%b ovf=%b v=%b want 1 0 0", bus.busy, bus.ovf, bus.bcdValid);
        end
        for (int i = 1; i <= 13; i++) tick();
        checks++;
        if (bus.bcdValid !== 1'b0) begin
            errors++;
            $display("FAIL e13_no_valid got %b want 0", bus.bcdValid);
        end
        tick();
        checks++;
        if ({bus.bcdValid, bus.opBCD, bus.ovf} !== {1'b1, exp, 1'b0}) begin
            errors++;
            $display("FAIL e14_load got v=%b bcd=%h ovf=%b want 1 1234 0", bus.bcdValid, bus.opBCD, bus.ovf);
        end
        for (int d = 3; d >= 0; d--) begin
            if (d != 3) tick();
            checks++;
            if ({bus.newNumber, bus.digitNumber, bus.digits} !== {1'b1, 2'(d), exp[d*4 +: 4]}) begin
                errors++;
                $display("FAIL stream_1234 got nn=%b n=%0d d=%h want 1 %0d %h",
                         bus.newNumber, bus.digitNumber, bus.digits, d, exp[d*4 +: 4]);
            end
        end
        checks++;
        if ({bus.busy, bus.bcdValid} !== 2'b10) begin
            errors++;
            $display("FAIL e17_state got busy=%b v=%b want 1 0", bus.busy, bus.bcdValid);
        end
        tick();
        checks++;
        if ({bus.busy, bus.newNumber, bus.opBCD} !== {2'b00, exp}) begin
            errors++;
            $display("FAIL e18_idle got busy=%b nn=%b bcd=%h want 0 0 1234", bus.busy, bus.newNumber, bus.opBCD);
        end
    endtask

    task automatic test_boundaries;
        logic [13:0] vin [2];
        logic [15:0] vexp [2];
        logic [15:0] e;
        vin[0] = 14'd0;    vexp[0] = 16'h0000;
        vin[1] = 14'd9999; vexp[1] = 16'h9999;
        for (int k = 0; k < 2; k++) begin
            e = vexp[k];
            start_conv(vin[k]);
            for (int i = 1; i <= 14; i++) tick();
            checks++;
            if ({bus.bcdValid, bus.opBCD, bus.ovf} !== {1'b1, e, 1'b0}) begin
                errors++;
                $display("FAIL boundary_%0d got v=%b bcd=%h ovf=%b want 1 %h 0", vin[k], bus.bcdValid, bus.opBCD, bus.ovf, e);
            end
            for (int d = 3; d >= 0; d--) begin
                if (d != 3) tick();
                checks++;
                if ({bus.newNumber, bus.digitNumber, bus.digits} !== {1'b1, 2'(d), e[d*4 +: 4]}) begin
                    errors++;
                    $display("FAIL boundary_stream_%0d got nn=%b n=%0d d=%h want 1 %0d %h",
                             vin[k], bus.newNumber, bus.digitNumber, bus.digits, d, e[d*4 +: 4]);
                end
            end
            tick();
            checks++;
            if (bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL boundary_idle_%0d got busy=%b want 0", vin[k], bus.busy);
            end
        end
    endtask

    task automatic test_overflow;
        logic [15:0] e;
`ifdef OVF_SATURATE_EN
        e = 16'h9999;
`else
        e = 16'h2345;
`endif
        start_conv(14'd12345);
        checks++;
        if (bus.ovf !== 1'b1) begin
            errors++;
            $display("FAIL ovf_e0 got %b want 1", bus.ovf);
        end
        for (int i = 1; i <= 14; i++) tick();
        checks++;
        if ({bus.bcdValid, bus.opBCD} !== {1'b1, e}) begin
            errors++;
            $display("FAIL ovf_load got v=%b bcd=%h want 1 %h", bus.bcdValid, bus.opBCD, e);
        end
        for (int d = 3; d >= 0; d--) begin
            if (d != 3) tick();
            checks++;
            if ({bus.newNumber, bus.digitNumber, bus.digits} !== {1'b1, 2'(d), e[d*4 +: 4]}) begin
                errors++;
                $display("FAIL ovf_stream got nn=%b n=%0d d=%h want 1 %0d %h",
                         bus.newNumber, bus.digitNumber, bus.digits, d, e[d*4 +: 4]);
            end
        end
        tick(); tick();
        checks++;
        if ({bus.busy, bus.ovf} !== 2'b01) begin
            errors++;
            $display("FAIL ovf_hold got busy=%b ovf=%b want 0 1", bus.busy, bus.ovf);
        end
    endtask

    task automatic test_hold;
        start_conv(14'd507);
        for (int i = 1; i <= 15; i++) tick();
        checks++;
        if ({bus.newNumber, bus.digitNumber, bus.digits, bus.opBCD} !== {1'b1, 2'd2, 4'd5, 16'h0507}) begin
            errors++;
            $display("FAIL hold_pre got nn=%b n=%0d d=%h bcd=%h want 1 2 5 0507",
                     bus.newNumber, bus.digitNumber, bus.digits, bus.opBCD);
        end
        bus.hold = 1'b1;
        for (int h = 0; h < 3; h++) begin
            tick();
            checks++;
            if ({bus.newNumber, bus.digitNumber, bus.digits, bus.busy} !== {1'b0, 2'd2, 4'd5, 1'b1}) begin
                errors++;
                $display("FAIL hold_frozen_%0d got nn=%b n=%0d d=%h busy=%b want 0 2 5 1",
                         h, bus.newNumber, bus.digitNumber, bus.digits, bus.busy);
            end
        end
        bus.hold = 1'b0;
        tick();
        checks++;
        if ({bus.newNumber, bus.digitNumber, bus.digits} !== {1'b1, 2'd1, 4'd0}) begin
            errors++;
            $display("FAIL hold_resume1 got nn=%b n=%0d d=%h want 1 1 0", bus.newNumber, bus.digitNumber, bus.digits);
        end
        tick();
        checks++;
        if ({bus.newNumber, bus.digitNumber, bus.digits, bus.busy} !== {1'b1, 2'd0, 4'd7, 1'b1}) begin
            errors++;
            $display("FAIL hold_resume0 got nn=%b n=%0d d=%h busy=%b want 1 0 7 1",
                     bus.newNumber, bus.digitNumber, bus.digits, bus.busy);
        end
        tick();
        checks++;
        if ({bus.busy, bus.newNumber} !== 2'b00) begin
            errors++;
            $display("FAIL hold_idle got busy=%b nn=%b want 0 0", bus.busy, bus.newNumber);
        end
    endtask

    task automatic test_ignored_start;
        int pulses;
        pulses = 0;
        start_conv(14'd100);
        for (int i = 1; i <= 17; i++) begin
            bus.start  = (i == 5) || (i == 17);
            bus.binary = 14'd4321;
            tick();
            pulses += int'(bus.bcdValid);
        end
        // start is high going into E18, the final EMIT edge
        tick();
        bus.start = 1'b0;
        pulses += int'(bus.bcdValid);
        checks++;
        if ({bus.busy, bus.opBCD} !== {1'b0, 16'h0100}) begin
            errors++;
            $display("FAIL ignored_final got busy=%b bcd=%h want 0 0100", bus.busy, bus.opBCD);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(bus.bcdValid);
        end
        checks++;
        if ({pulses, bus.busy, bus.opBCD} !== {32'd1, 1'b0, 16'h0100}) begin
            errors++;
            $display("FAIL ignored_pulses got pulses=%0d busy=%b bcd=%h want 1 0 0100", pulses, bus.busy, bus.opBCD);
        end
    endtask

    task automatic test_reset_mid_conv;
        int pulses;
        pulses = 0;
        start_conv(14'd1234);
        tick(); tick(); tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({bus.busy, bus.bcdValid, bus.opBCD, bus.ovf, bus.digits, bus.digitNumber, bus.newNumber} !== 26'd0) begin
            errors++;
            $display("FAIL reset_mid got busy=%b v=%b bcd=%h ovf=%b d=%h n=%0d nn=%b want all zero",
                     bus.busy, bus.bcdValid, bus.opBCD, bus.ovf, bus.digits, bus.digitNumber, bus.newNumber);
        end
        tick();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            pulses += int'(bus.bcdValid) + int'(bus.busy);
        end
        checks++;
        if ({pulses, bus.opBCD} !== {32'd0, 16'h0000}) begin
            errors++;
            $display("FAIL reset_after got activity=%0d bcd=%h want 0 0000", pulses, bus.opBCD);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset_state();
        test_basic_1234();
        test_boundaries();
        test_overflow();
        test_hold();
        test_ignored_start();
        test_reset_mid_conv();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
